// File: rtl/checkbits_latency_monitor.sv
// rtl/checkbits_latency_monitor.sv - run-latency monitor for the checkbits status word
// Filters checkbits, times START..END in hardware and queues intermediate checkpoint values.
module checkbits_latency_monitor #(
  parameter logic [15:0] START_CODE    = 16'h00A5,
  parameter logic [15:0] END_CODE      = 16'h005A,
  parameter int          STABLE_CYCLES = 2,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          CNT_W         = 32
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [15:0]      checkbits,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] latency,
  output logic             overflow,
  output logic             mid_valid,
  input  logic             mid_ready,
  output logic [15:0]      mid_data,
  output logic [7:0]       drop_cnt
);

  localparam int                 PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [3:0]         STABLE_N = 4'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [PTR_W:0]     FILL_MAX = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [15:0]      sample;
  logic [3:0]       run_len;
  logic             same;
  logic             accept;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_inc;
  logic             is_start;
  logic             is_end;
  logic             push;
  logic             pop;
  logic             full;
  logic             do_write;
  logic             drop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fill;
  logic [15:0]      mem [FIFO_DEPTH];

  // A value is accepted on the single edge where its run length reaches STABLE_CYCLES.
  always_comb begin
    same   = (checkbits == sample);
    accept = same ? (run_len == STABLE_N - 4'd1) : (STABLE_N == 4'd1);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sample  <= 16'h0000;
      run_len <= 4'd0;
    end else begin
      sample <= checkbits;
      if (clear)
        run_len <= 4'd0;
      else if (!same)
        run_len <= 4'd1;
      else if (run_len != STABLE_N)
        run_len <= run_len + 4'd1;
    end
  end

  always_comb begin
    cnt_inc  = (count == CNT_MAX) ? CNT_MAX : count + 1'b1;
    is_start = accept && (checkbits == START_CODE);
    is_end   = accept && (checkbits == END_CODE);
    push     = (state == S_RUN) && accept && !is_start && !is_end && !clear;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state    <= S_IDLE;
      count    <= '0;
      latency  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      state    <= S_IDLE;
      count    <= '0;
      latency  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_start) begin
            state    <= S_RUN;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        S_RUN: begin
          if (is_end) begin
            latency <= cnt_inc;
            done    <= 1'b1;
            state   <= S_DONE;
            if (cnt_inc == CNT_MAX)
              overflow <= 1'b1;
          end else if (is_start) begin
            count    <= '0;
            overflow <= 1'b0;
          end else begin
            count <= cnt_inc;
            if (cnt_inc == CNT_MAX)
              overflow <= 1'b1;
          end
        end
        S_DONE: begin
          if (is_start) begin
            state    <= S_RUN;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);

  // A pop frees the slot in the same cycle, so a push into a full FIFO with a pop is not dropped.
  always_comb begin
    mid_valid = (fill != '0);
    full      = (fill == FILL_MAX);
    pop       = mid_valid && mid_ready && !clear;
    do_write  = push && (!full || pop);
    drop      = push && full && !pop;
    mid_data  = mid_valid ? mem[rd_ptr] : 16'h0000;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      drop_cnt <= 8'h00;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      drop_cnt <= 8'h00;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'h01;
    end
  end

  always_ff @(posedge clock) begin
    if (do_write)
      mem[wr_ptr] <= checkbits;
  end

endmodule

// File: tb/tb_checkbits_latency_monitor.sv
// tb/tb_checkbits_latency_monitor.sv - self-checking bench for checkbits_latency_monitor
// Table of held checkbits values with expected outputs, plus hand sequences for saturation and reset.
module tb_checkbits_latency_monitor;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [15:0] checkbits = 16'h0000;
  logic        clear = 1'b0;
  logic        mid_ready = 1'b0;

  logic        busy, done, overflow, mid_valid;
  logic [31:0] latency;
  logic [15:0] mid_data;
  logic [7:0]  drop_cnt;

  logic        busy8, done8, overflow8, mid_valid8;
  logic [7:0]  latency8;
  logic [15:0] mid_data8;
  logic [7:0]  drop_cnt8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  checkbits_latency_monitor dut (
    .clock(clock), .resetb(resetb), .checkbits(checkbits), .clear(clear),
    .busy(busy), .done(done), .latency(latency), .overflow(overflow),
    .mid_valid(mid_valid), .mid_ready(mid_ready), .mid_data(mid_data), .drop_cnt(drop_cnt)
  );

  checkbits_latency_monitor #(.CNT_W(8)) dut8 (
    .clock(clock), .resetb(resetb), .checkbits(checkbits), .clear(clear),
    .busy(busy8), .done(done8), .latency(latency8), .overflow(overflow8),
    .mid_valid(mid_valid8), .mid_ready(mid_ready), .mid_data(mid_data8), .drop_cnt(drop_cnt8)
  );

  typedef struct {
    logic [15:0] cb;
    int          cyc;
    logic        rdy;
    logic        clr;
    logic        busy;
    logic        done;
    logic [31:0] lat;
    logic        ovf;
    logic        mv;
    logic [15:0] md;
    logic [7:0]  drop;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [15:0] cb, input int cyc, input logic rdy, input logic clr,
                     input logic b, input logic d, input logic [31:0] lat, input logic ovf,
                     input logic mv, input logic [15:0] md, input logic [7:0] drop);
    vec_t v;
    v.cb = cb; v.cyc = cyc; v.rdy = rdy; v.clr = clr;
    v.busy = b; v.done = d; v.lat = lat; v.ovf = ovf; v.mv = mv; v.md = md; v.drop = drop;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".latency"}, latency, 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
    chk({tag, ".mid_valid"}, 32'(mid_valid), 32'd0);
    chk({tag, ".mid_data"}, 32'(mid_data), 32'd0);
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    //   cb        cyc rdy clr  busy done lat ovf mv  md        drop
    // basic latency: START held 10 edges, 0x0000 for 90, then END
    add(16'h00A5,  1, 0, 0,   0, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h00A5,  1, 0, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h00A5,  8, 0, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h0000, 90, 0, 0,   1, 0,   0, 0, 1, 16'h0000, 0);
    add(16'h005A,  2, 0, 0,   0, 1, 100, 0, 1, 16'h0000, 0);
    add(16'h005A,  5, 0, 0,   0, 1, 100, 0, 1, 16'h0000, 0);
    add(16'h0000,  1, 1, 0,   0, 1, 100, 0, 0, 16'h0000, 0);
    add(16'h0000,  1, 0, 1,   0, 0,   0, 0, 0, 16'h0000, 0);
    // glitch: one-edge END blip, real END 50 edges after it
    add(16'h00A5,  3, 0, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h005A,  1, 0, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h0011, 49, 0, 0,   1, 0,   0, 0, 1, 16'h0011, 0);
    add(16'h005A,  2, 0, 0,   0, 1,  53, 0, 1, 16'h0011, 0);
    add(16'h005A,  1, 0, 1,   0, 0,   0, 0, 0, 16'h0000, 0);
    // intermediates 40, 893, 9073 under back-pressure, then drained
    add(16'h00A5,  3, 0, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'd40,    5, 0, 0,   1, 0,   0, 0, 1, 16'd40,   0);
    add(16'd893,   5, 0, 0,   1, 0,   0, 0, 1, 16'd40,   0);
    add(16'd9073,  5, 0, 0,   1, 0,   0, 0, 1, 16'd40,   0);
    add(16'd9073,  1, 1, 0,   1, 0,   0, 0, 1, 16'd893,  0);
    add(16'd9073,  1, 1, 0,   1, 0,   0, 0, 1, 16'd9073, 0);
    add(16'd9073,  1, 1, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'd9073,  1, 0, 1,   0, 0,   0, 0, 0, 16'h0000, 0);
    // six pushes into a depth-4 FIFO, then push+pop while full
    add(16'h00A5,  3, 0, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h0101,  3, 0, 0,   1, 0,   0, 0, 1, 16'h0101, 0);
    add(16'h0202,  3, 0, 0,   1, 0,   0, 0, 1, 16'h0101, 0);
    add(16'h0303,  3, 0, 0,   1, 0,   0, 0, 1, 16'h0101, 0);
    add(16'h0404,  3, 0, 0,   1, 0,   0, 0, 1, 16'h0101, 0);
    add(16'h0505,  3, 0, 0,   1, 0,   0, 0, 1, 16'h0101, 1);
    add(16'h0606,  3, 0, 0,   1, 0,   0, 0, 1, 16'h0101, 2);
    add(16'h0707,  1, 0, 0,   1, 0,   0, 0, 1, 16'h0101, 2);
    add(16'h0707,  1, 1, 0,   1, 0,   0, 0, 1, 16'h0202, 2);
    add(16'h0707,  1, 1, 0,   1, 0,   0, 0, 1, 16'h0303, 2);
    add(16'h0707,  1, 1, 0,   1, 0,   0, 0, 1, 16'h0404, 2);
    add(16'h0707,  1, 1, 0,   1, 0,   0, 0, 1, 16'h0707, 2);
    add(16'h0707,  1, 1, 0,   1, 0,   0, 0, 0, 16'h0000, 2);
    add(16'h0707,  1, 0, 1,   0, 0,   0, 0, 0, 16'h0000, 0);
    // restart inside RUN keeps the FIFO, then restart from DONE
    add(16'h00A5,  3, 0, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h0000, 10, 0, 0,   1, 0,   0, 0, 1, 16'h0000, 0);
    add(16'h00A5,  5, 0, 0,   1, 0,   0, 0, 1, 16'h0000, 0);
    add(16'h005A,  2, 0, 0,   0, 1,   5, 0, 1, 16'h0000, 0);
    add(16'h00A5,  2, 0, 0,   1, 0,   5, 0, 1, 16'h0000, 0);
    add(16'h005A,  3, 0, 0,   0, 1,   2, 0, 1, 16'h0000, 0);
    add(16'h005A,  1, 0, 1,   0, 0,   0, 0, 0, 16'h0000, 0);
    // clear on the same edge END is accepted
    add(16'h00A5,  3, 0, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h005A,  1, 0, 0,   1, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h005A,  1, 0, 1,   0, 0,   0, 0, 0, 16'h0000, 0);
    add(16'h005A,  3, 0, 0,   0, 0,   0, 0, 0, 16'h0000, 0);

    step(2);
    chk_all_zero("reset");
    chk("reset.dut8.busy", 32'(busy8), 32'd0);
    chk("reset.dut8.latency", 32'(latency8), 32'd0);
    resetb = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      checkbits = vt[i].cb;
      mid_ready = vt[i].rdy;
      clear     = vt[i].clr;
      step(vt[i].cyc);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("v%0d.done", i), 32'(done), 32'(vt[i].done));
      chk($sformatf("v%0d.latency", i), latency, vt[i].lat);
      chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vt[i].ovf));
      chk($sformatf("v%0d.mid_valid", i), 32'(mid_valid), 32'(vt[i].mv));
      chk($sformatf("v%0d.mid_data", i), 32'(mid_data), 32'(vt[i].md));
      chk($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt), 32'(vt[i].drop));
    end
    clear = 1'b0;
    mid_ready = 1'b0;

    // 300-edge run: the 8-bit counter saturates, the 32-bit one does not
    checkbits = 16'h00A5;
    step(3);
    checkbits = 16'h0000;
    step(297);
    chk("sat.dut8.busy", 32'(busy8), 32'd1);
    chk("sat.dut8.overflow_in_run", 32'(overflow8), 32'd1);
    chk("sat.dut.overflow_in_run", 32'(overflow), 32'd0);
    checkbits = 16'h005A;
    step(2);
    chk("sat.dut8.done", 32'(done8), 32'd1);
    chk("sat.dut8.latency", 32'(latency8), 32'd255);
    chk("sat.dut8.overflow", 32'(overflow8), 32'd1);
    chk("sat.dut.latency", latency, 32'd300);
    chk("sat.dut.overflow", 32'(overflow), 32'd0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("sat.clear.dut8.overflow", 32'(overflow8), 32'd0);

    // asynchronous reset in the middle of a run with a queued value
    checkbits = 16'h00A5;
    step(3);
    checkbits = 16'h1234;
    step(3);
    chk("rst.pre.busy", 32'(busy), 32'd1);
    chk("rst.pre.mid_valid", 32'(mid_valid), 32'd1);
    chk("rst.pre.mid_data", 32'(mid_data), 32'h1234);
    #2 resetb = 1'b0;
    #1;
    chk_all_zero("rst.async");
    @(posedge clock);
    #1 resetb = 1'b1;
    step(3);
    chk("rst.post.busy", 32'(busy), 32'd0);
    chk("rst.post.mid_valid", 32'(mid_valid), 32'd0);
    checkbits = 16'h00A5;
    step(2);
    chk("rst.post.start.busy", 32'(busy), 32'd1);
    chk("rst.post.start.mid_valid", 32'(mid_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/checkbits_latency_monitor.md
# checkbits_latency_monitor

Synthesizable monitor that consumes the 16-bit firmware status word driven on mprj_io[31:16] ("checkbits") and measures run latency in hardware. A run starts at the start code (0x00A5) and ends at the end code (0x005A). The block captures any intermediate checkpoint values, such as qs() return values, in a small FIFO. It sits directly downstream of the checkbits GPIO bus in the user project and replaces bench-side cycle counting, so the same latency figure is available on silicon.

## Interface
- START_CODE, 16'h00A5, status value that starts a run
- END_CODE, 16'h005A, status value that ends a run
- STABLE_CYCLES, 2, consecutive identical samples required to accept a value (range 1..15)
- FIFO_DEPTH, 4, intermediate-value FIFO depth (power of 2, ≥2)
- CNT_W, 32, latency counter width
- clock  in  1  sole clock, rising edge
- resetb  in  1  asynchronous, active-low reset
- checkbits  in  16  status word (mprj_io[31:16]), synchronous to clock
- clear  in  1  synchronous clear of results and FSM
- busy  out  1  run in progress
- done  out  1  latency valid
- latency  out  CNT_W  measured cycles, start to end
- overflow  out  1  latency saturated
- mid_valid  out  1  FIFO non-empty
- mid_ready  in  1  consumer accepts mid_data
- mid_data  out  16  oldest intermediate value (first-word fall-through)
- drop_cnt  out  8  intermediate values lost to a full FIFO, saturating

## Operation
- **Filter.** checkbits is registered every edge, and a run-length counter tracks consecutive identical samples.
  - A value is *accepted* once, on the edge where its run length reaches STABLE_CYCLES.
  - An unchanged value is never re-accepted.
  - Shorter glitches are ignored.
- **FSM states:** IDLE, RUN, DONE.
  - **IDLE:** accepting START_CODE moves to RUN with count=0. Other values are ignored.
  - **RUN:** count increments every edge and saturates at all-ones; overflow is set on reaching saturation.
    - Accepting END_CODE: latency←count+1 (saturating, which sets overflow), done←1, go to DONE.
    - Accepting START_CODE: restart with count=0 and overflow cleared. The FIFO is kept.
    - Accepting any other value: push it to the FIFO.
  - **DONE:** latency, done and overflow hold.
    - Accepting START_CODE: go to RUN, with done←0 and count=0.
    - Other values are ignored.
- **FIFO.**
  - Push with the FIFO full: the value is dropped and drop_cnt increments, saturating at 255.
  - Pop occurs on mid_valid && mid_ready.
  - Pop and push in the same cycle while full: both succeed and nothing is dropped.
- **clear.**
  - Returns the FSM to IDLE and zeroes latency, done, overflow, drop_cnt and count.
  - Flushes the FIFO and resets the filter run length.
  - Has priority over any acceptance or pop in the same cycle.
- **Reset (resetb low).** All outputs are 0: busy, done, latency, overflow, mid_valid, mid_data, drop_cnt. The FSM is IDLE and the sample register is 0. Reset mid-run abandons the run with no residual state.
- busy = (state==RUN), registered.

## Timing
- A value first sampled at edge k is accepted at edge k+STABLE_CYCLES−1.
  - Resulting outputs (busy, done, latency, FIFO push/mid_valid) are visible after that edge.
- Latency equals the edge distance between first samples of START and END. The constant filter delay cancels.
  - Example: START first sampled at edge k, END first sampled at edge m gives latency = m−k.
- FIFO: a push at edge e makes mid_valid high after e.
  - mid_data is valid whenever mid_valid=1 and is stable until popped.
- drop_cnt updates on the same edge as the rejected push.

## Test plan
- **Basic latency.** Hold checkbits=0x00A5 for 10 cycles, 0x0000 for 90 cycles, then 0x005A.
  - Required: busy=1 two edges after 0x00A5 appears; done=1, latency=100, overflow=0; busy=0.
- **Glitch filter.** During a run, drive a 1-cycle 0x005A blip, then the real 0x005A 50 cycles later.
  - Required: the blip is ignored, the run continues, and latency counts to the real end.
- **Intermediates with back-pressure.** In a run, drive values 40, 893, 9073 (each 5 cycles) with mid_ready=0, then raise mid_ready.
  - Required: mid_data pops in order 40, 893, 9073; mid_valid then 0; drop_cnt=0.
- **Overflow and saturation.**
  - With mid_ready=0, push 6 distinct values at FIFO_DEPTH=4: drop_cnt=2, and first four retained in order.
  - With CNT_W=8 and a 300-cycle run: latency=255, overflow=1.
- **Reset mid-run and clear collision.**
  - resetb low during RUN: all outputs 0 immediately.
  - clear asserted on the same edge END is accepted: done=0, latency=0, state IDLE.
- **Restart.**
  - START re-accepted while in RUN: count restarts from 0.
  - START accepted while in DONE: done drops and busy rises.
